// File: rtl/arinc429_pkg.sv
// Shared constants, speed codes and FSM encoding for the ARINC 429 transmit queue.
package arinc429_pkg;

  localparam int WORD_W = 32;
  localparam int ADR_W  = 8;
  localparam int DAT_W  = 23;

  localparam int RATE_12K5 = 12500;
  localparam int RATE_50K  = 50000;
  localparam int RATE_100K = 100000;

  typedef enum logic [1:0] {
    NVEL_12K5     = 2'd0,
    NVEL_50K      = 2'd1,
    NVEL_100K     = 2'd2,
    NVEL_100K_ALT = 2'd3
  } nvel_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_NULL = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/arinc429_txq_if.sv
// Push-side bus of the ARINC 429 transmit queue.
// ARINC429_TXQ_ERRINJ_EN adds the per-word parity-inversion flag inj.
interface arinc429_txq_if;
  import arinc429_pkg::*;

  logic             wr;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat;
`ifdef ARINC429_TXQ_ERRINJ_EN
  logic             inj;
`endif
  logic             full;
  logic             empty;
  logic             ovf;

  modport master (
    output wr, adr, dat,
`ifdef ARINC429_TXQ_ERRINJ_EN
    output inj,
`endif
    input  full, empty, ovf
  );

  modport slave (
    input  wr, adr, dat,
`ifdef ARINC429_TXQ_ERRINJ_EN
    input  inj,
`endif
    output full, empty, ovf
  );

endinterface

// File: rtl/arinc429_fifo.sv
// Synchronous word queue with registered count; read data is registered every cycle
// so the head word is valid one cycle after it lands or after the previous pop.
module arinc429_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = rd_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
    rd_data_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/arinc429_txq.sv
// ARINC 429 transmitter: queued words are sent as bipolar RZ with odd parity.
// ARINC429_TXQ_ERRINJ_EN enables the inj flag that forces even parity on a word.
module arinc429_txq
  import arinc429_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_BITS   = 4
) (
  input  logic           GCLK,
  input  logic           rst,
  input  logic [1:0]     nvel,
  arinc429_txq_if.slave  bus,
  output logic           TXD0,
  output logic           TXD1,
  output logic           busy,
  output logic           sent
);

  localparam int HALF_12K5  = CLK_HZ / (2 * RATE_12K5);
  localparam int HALF_50K   = CLK_HZ / (2 * RATE_50K);
  localparam int HALF_100K  = CLK_HZ / (2 * RATE_100K);
  localparam int HB_W       = $clog2(HALF_12K5 + 1);
  localparam int GAP_HALVES = 2 * GAP_BITS;
  localparam int BIT_W      = $clog2(max_int(WORD_W, GAP_HALVES));
`ifdef ARINC429_TXQ_ERRINJ_EN
  localparam int Q_W = ADR_W + DAT_W + 1;
`else
  localparam int Q_W = ADR_W + DAT_W;
`endif

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [HB_W-1:0]   hb_reg, hb_next;
  logic [HB_W-1:0]   hlm1_reg, hlm1_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic              txd0_reg, txd0_next;
  logic              txd1_reg, txd1_next;
  logic              sent_reg, sent_next;
  logic              ovf_reg;

  logic [Q_W-1:0]    q_wdata;
  logic [Q_W-1:0]    q_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [ADR_W-1:0]  q_adr;
  logic [DAT_W-1:0]  q_dat;
  logic [DAT_W-1:0]  dat_rev;
  logic [WORD_W-2:0] payload;
  logic              parity;
  logic [WORD_W-1:0] load_word;
  logic [HB_W-1:0]   half_sel;

`ifdef ARINC429_TXQ_ERRINJ_EN
  assign q_wdata = {bus.adr, bus.dat, bus.inj};
  assign q_adr   = q_rdata[Q_W-1 -: ADR_W];
  assign q_dat   = q_rdata[Q_W-1-ADR_W -: DAT_W];
  assign parity  = ~(^payload) ^ q_rdata[0];
`else
  assign q_wdata = {bus.adr, bus.dat};
  assign q_adr   = q_rdata[Q_W-1 -: ADR_W];
  assign q_dat   = q_rdata[DAT_W-1:0];
  assign parity  = ~(^payload);
`endif

  arinc429_fifo #(
    .WIDTH (Q_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (GCLK),
    .rst     (rst),
    .wr_en   (bus.wr),
    .wr_data (q_wdata),
    .rd_en   (pop),
    .rd_data (q_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Label goes out MSB-first, data LSB-first, so only the data field is mirrored.
  for (genvar gi = 0; gi < DAT_W; gi++) begin : g_dat_rev
    assign dat_rev[DAT_W-1-gi] = q_dat[gi];
  end

  assign payload   = {q_adr, dat_rev};
  assign load_word = {payload, parity};

  always_comb begin
    case (nvel_t'(nvel))
      NVEL_12K5: half_sel = HB_W'(HALF_12K5);
      NVEL_50K:  half_sel = HB_W'(HALF_50K);
      default:   half_sel = HB_W'(HALF_100K);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    hb_next    = hb_reg;
    hlm1_next  = hlm1_reg;
    bit_next   = bit_reg;
    sent_next  = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        pop        = 1'b1;
        shift_next = load_word;
        hlm1_next  = half_sel - HB_W'(1);
        hb_next    = half_sel - HB_W'(1);
        bit_next   = BIT_W'(WORD_W - 1);
        state_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (hb_reg == '0) begin
          hb_next    = hlm1_reg;
          state_next = ST_NULL;
        end else begin
          hb_next = hb_reg - HB_W'(1);
        end
      end
      ST_NULL: begin
        if (hb_reg == '0) begin
          hb_next = hlm1_reg;
          if (bit_reg == '0) begin
            sent_next  = 1'b1;
            bit_next   = BIT_W'(GAP_HALVES - 1);
            state_next = ST_GAP;
          end else begin
            bit_next   = bit_reg - BIT_W'(1);
            shift_next = {shift_reg[WORD_W-2:0], 1'b0};
            state_next = ST_HIGH;
          end
        end else begin
          hb_next = hb_reg - HB_W'(1);
        end
      end
      ST_GAP: begin
        // bit_reg counts remaining half-bits of the gap here.
        if (hb_reg == '0) begin
          hb_next = hlm1_reg;
          if (bit_reg == '0) begin
            state_next = fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            bit_next = bit_reg - BIT_W'(1);
          end
        end else begin
          hb_next = hb_reg - HB_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    txd1_next = (state_next == ST_HIGH) &&  shift_next[WORD_W-1];
    txd0_next = (state_next == ST_HIGH) && !shift_next[WORD_W-1];
  end

  always_ff @(posedge GCLK or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      hb_reg    <= '0;
      hlm1_reg  <= '0;
      bit_reg   <= '0;
      txd0_reg  <= 1'b0;
      txd1_reg  <= 1'b0;
      sent_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      hb_reg    <= hb_next;
      hlm1_reg  <= hlm1_next;
      bit_reg   <= bit_next;
      txd0_reg  <= txd0_next;
      txd1_reg  <= txd1_next;
      sent_reg  <= sent_next;
      ovf_reg   <= bus.wr && fifo_full;
    end
  end

  assign TXD0      = txd0_reg;
  assign TXD1      = txd1_reg;
  assign sent      = sent_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign bus.full  = fifo_full;
  assign bus.empty = fifo_empty;
  assign bus.ovf   = ovf_reg;

endmodule

// File: doc/arinc429_txq.md
ARINC429_TXQ -- requirements
Module: arinc429_txq

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the GCLK frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the word-queue depth (power of 2, at least 2).
REQ-003 SHALL have parameter GAP_BITS, default 4, meaning the minimum inter-word null gap in bit-times (at least 4).
REQ-004 SHALL provide ports: GCLK  in  1  the single clock; reset is asynchronous and active-high.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 nvel  in  2  speed select: 0 = 12.5 kbps, 1 = 50 kbps, 2 and 3 = 100 kbps.
REQ-007 wr  in  1  push strobe, one word per high cycle.
REQ-008 adr  in  8  label, captured with wr.
REQ-009 dat  in  23  data field, captured with wr.
REQ-010 TXD0, TXD1  out  1 each  bipolar return-to-zero line pair.
REQ-011 full, empty  out  1 each  queue status.
REQ-012 busy  out  1  high while a word or gap is in progress.
REQ-013 sent  out  1  one-cycle pulse at the end of each word's bit 32.
REQ-014 ovf  out  1  one-cycle pulse when a push is dropped.

Function
REQ-015 SHALL push {adr,dat} on a cycle with wr=1 and full=0; wr=1 with full=1 SHALL drop the word and pulse ovf the next cycle.
REQ-016 full SHALL be evaluated on the pre-cycle count, so wr while full SHALL be dropped even when a pop occurs in the same cycle.
REQ-017 The word order SHALL be adr[7] down to adr[0], then dat[0] up to dat[22], then the parity bit, for 32 bits total.
REQ-018 Parity SHALL be odd over all 32 bits.
REQ-019 Half-bit length SHALL be CLK_HZ/(2*rate) cycles, and nvel SHALL be sampled only in LOAD.
REQ-020 A '1' bit SHALL drive TXD1=1, TXD0=0 for the first half-bit; a '0' bit SHALL drive TXD0=1, TXD1=0; both lines SHALL be 0 in the second half-bit.
REQ-021 TXD0 and TXD1 SHALL never be 1 simultaneously, and both SHALL be 0 when idle.
REQ-022 The FSM SHALL cycle IDLE -> LOAD -> HIGH <-> NULL -> GAP -> (LOAD if !empty, else IDLE).
REQ-023 IDLE SHALL go to LOAD on the first cycle in which empty=0.
REQ-024 LOAD SHALL pop the queue and latch the 32-bit shift word, taking one cycle.
REQ-025 The first HIGH half-bit SHALL start 2 cycles after wr into an empty, idle block.
REQ-026 NULL after bit 32 SHALL pulse sent, then enter GAP.
REQ-027 GAP SHALL hold both lines at 0 for GAP_BITS*2 half-bits.
REQ-028 busy SHALL be 1 in all states except IDLE.
REQ-029 The half-bit counter and bit counter SHALL be sized via $clog2 and SHALL wrap only by explicit reload.

Reset
REQ-030 rst=1 SHALL asynchronously force TXD0=TXD1=0, full=0, empty=1, busy=0, sent=0, ovf=0, the FSM to IDLE, and all queue pointers and counters to 0.
REQ-031 Reset mid-word SHALL abort the word, discard the queue contents, and emit no sent pulse.
REQ-032 After rst falls, the first push SHALL be accepted on the next rising edge.

Configuration
REQ-033 With ARINC429_TXQ_ERRINJ_EN defined, an input inj (1 bit) SHALL be queued with each word, and inj=1 SHALL invert that word's parity bit (even parity).
REQ-034 Without ARINC429_TXQ_ERRINJ_EN, the inj port and its storage SHALL be absent and parity SHALL always be odd.

Structure
REQ-035 Package arinc429_pkg SHALL hold the speed codes, the rate constants (12500, 50000, 100000), WORD_W=32, and the FSM state encoding.
REQ-036 The queue SHALL be sub-module arinc429_fifo (synchronous, registered count), parameterised by width and depth.

Verification
REQ-037 Single word: nvel=2, adr=8'hAF, dat=23'h0ABCDE -> TXD1 high for cycles 2..251; bit pattern AF MSB-first then data LSB-first; parity bit 0 (19 ones); sent at 16002 cycles.
REQ-038 Back-to-back: two pushes, nvel=2 -> second word's first half-bit starts 2000 cycles plus 1 LOAD cycle after the first word's sent pulse.
REQ-039 Overflow: with TX stalled at the start, 9 pushes at depth 8 -> full=1 after the 8th push, ovf pulses once, the 9th word is never transmitted.
REQ-040 Low speed: nvel=0 -> half-bit of 2000 cycles, word in 128000 cycles; an nvel change mid-word has no effect until the next LOAD.
REQ-041 Reset mid-word at bit 10 -> both lines 0 within the same cycle, empty=1, busy=0, no sent pulse.
REQ-042 ERRINJ_EN build: inj=1 with the REQ-037 word -> parity bit 1, and all other bits identical to REQ-037.
